// File: rtl/dac_spi_sequencer_if.sv
// Command channel between user logic and the DAC SPI sequencer.
// Handshake: a command transfers on a rising CLOCK edge where IN_VALID and IN_READY are both 1. The master holds IN_VALID and all IN_* fields stable until that edge. IN_READY is registered and never depends combinationally on IN_VALID.
interface dac_spi_sequencer_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [3:0]            IN_CMD;
  logic [3:0]            IN_CHANNEL;
  logic                  IN_BROADCAST;
  logic [DATA_WIDTH-1:0] IN_DATA;

  modport master (
    output IN_VALID, IN_CMD, IN_CHANNEL, IN_BROADCAST, IN_DATA,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID, IN_CMD, IN_CHANNEL, IN_BROADCAST, IN_DATA,
    output IN_READY
  );
endinterface

// File: rtl/dac_spi_sequencer.sv
// SPI master for a 4-channel serial DAC: power-up clear, 32-bit command frames,
// MISO echo capture and a completed-frame counter.
module dac_spi_sequencer #(
  parameter int CLK_DIV      = 2,
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_CHANNELS = 4,
  parameter int CLR_CYCLES   = 16,
  parameter int CS_GAP       = 4
) (
  input  logic                CLOCK,
  input  logic                RESET,
  dac_spi_sequencer_if.slave  cmd,
  output logic                SPI_SCK,
  output logic                SPI_MOSI,
  input  logic                SPI_MISO,
  output logic                DAC_CS,
  output logic                DAC_CLR,
  output logic                DONE,
  output logic [31:0]         ECHO,
  output logic                ERROR,
  output logic [7:0]          CHECK,
  output logic [1:0]          DBG_STATE
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int GAP_W = $clog2(CS_GAP + 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             clr_q, clr_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      tx_q, tx_d;
  logic [31:0]      rx_q, rx_d;
  logic [31:0]      echo_q, echo_d;
  logic [7:0]       check_q, check_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [6:0]       half_q, half_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic [15:0] data_aligned;
  logic [31:0] frame_w;
  logic        bad_chan;

  assign data_aligned = 16'(cmd.IN_DATA) << (16 - DATA_WIDTH);
  assign frame_w      = {8'h00, cmd.IN_CMD,
                         cmd.IN_BROADCAST ? 4'hF : cmd.IN_CHANNEL, data_aligned};
  assign bad_chan     = !cmd.IN_BROADCAST &&
                        ({1'b0, cmd.IN_CHANNEL} >= 5'(NUM_CHANNELS));

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    tx_d      = tx_q;
    rx_d      = rx_q;
    echo_d    = echo_q;
    check_d   = check_q;
    div_d     = div_q;
    half_d    = half_q;
    clr_cnt_d = clr_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_CLEAR: begin
        // DAC_CLR rises first; IDLE (and IN_READY) follows one clock later.
        if (clr_q) begin
          state_d = ST_IDLE;
        end else if (int'(clr_cnt_q) == CLR_CYCLES - 1) begin
          clr_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd.IN_VALID && ready_q) begin
          if (bad_chan) begin
            error_d = 1'b1;
          end else begin
            tx_d    = frame_w;
            cs_d    = 1'b0;
            sck_d   = 1'b0;
            div_d   = '0;
            half_d  = '0;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        // half_q counts completed SCK half-periods; the 65th ends the frame.
        if (int'(div_q) == CLK_DIV - 1) begin
          div_d  = '0;
          half_d = half_q + 7'd1;
          if (half_q == 7'd64) begin
            cs_d      = 1'b1;
            done_d    = 1'b1;
            echo_d    = rx_q;
            check_d   = check_q + 8'd1;
            tx_d      = '0;
            gap_cnt_d = '0;
            state_d   = (CS_GAP == 1) ? ST_IDLE : ST_GAP;
          end else if (!half_q[0]) begin
            sck_d = 1'b1;
            rx_d  = {rx_q[30:0], SPI_MISO};
          end else begin
            sck_d = 1'b0;
            tx_d  = {tx_q[30:0], 1'b0};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        // The accept edge itself is the last high clock of the CS gap.
        if (int'(gap_cnt_q) == CS_GAP - 2) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_CLEAR;
      ready_q   <= 1'b0;
      clr_q     <= 1'b0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      echo_q    <= '0;
      check_q   <= '0;
      div_q     <= '0;
      half_q    <= '0;
      clr_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      clr_q     <= clr_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      done_q    <= done_d;
      error_q   <= error_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      echo_q    <= echo_d;
      check_q   <= check_d;
      div_q     <= div_d;
      half_q    <= half_d;
      clr_cnt_q <= clr_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign cmd.IN_READY = ready_q;
  assign SPI_SCK      = sck_q;
  assign SPI_MOSI     = tx_q[31];
  assign DAC_CS       = cs_q;
  assign DAC_CLR      = clr_q;
  assign DONE         = done_q;
  assign ECHO         = echo_q;
  assign ERROR        = error_q;
  assign CHECK        = check_q;
  assign DBG_STATE    = state_q;

endmodule

// File: doc/dac_spi_sequencer.md
Name: dac_spi_sequencer

Overview:
Parametrised SPI master for the board's 4-channel 12-bit serial DAC (32-bit command frames). Replaces the fixed single-word DAC driver with the following features:
- valid/ready command interface
- programmable SCK divider
- per-channel and broadcast addressing
- power-up clear sequencing
- MISO echo capture
- frame counter for the LEDs

Sits between user logic, which runs on the system clock (no slow-clock divider needed), and the SPI pins.

Parameters:
CLK_DIV, 2, system clocks per SCK half-period (>=1)
DATA_WIDTH, 12, DAC code width (1..16)
NUM_CHANNELS, 4, addressable DAC channels (1..15)
CLR_CYCLES, 16, clocks DAC_CLR held low after reset release (>=1)
CS_GAP, 4, clocks DAC_CS held high between frames (>=1)

Ports:
CLOCK  in  1  system clock; all logic on rising edge
RESET  in  1  synchronous, active-high reset
IN_VALID  in  1  command present
IN_READY  out  1  block can accept command
IN_CMD  in  4  DAC command nibble (e.g. 4'b0011 write+update)
IN_CHANNEL  in  4  target channel 0..NUM_CHANNELS-1
IN_BROADCAST  in  1  1 = address all channels (addr 4'hF), IN_CHANNEL ignored
IN_DATA  in  DATA_WIDTH  DAC code
SPI_SCK  out  1  serial clock, idle low
SPI_MOSI  out  1  serial data, MSB first
SPI_MISO  in  1  DAC echo data
DAC_CS  out  1  chip select, active low
DAC_CLR  out  1  DAC async clear, active low
DONE  out  1  one-cycle pulse: frame completed
ECHO  out  32  word shifted in on MISO during last completed frame
ERROR  out  1  one-cycle pulse: command rejected (bad channel)
CHECK  out  8  completed-frame count mod 256 (LED debug)

Behaviour:
Reset values (cycle after RESET sampled high):
- SPI_SCK=0, SPI_MOSI=0, DAC_CS=1, DAC_CLR=0
- IN_READY=0, DONE=0, ERROR=0, ECHO=0, CHECK=0
- State=CLEAR

Reset mid-frame:
- Frame is abandoned: CS high, SCK low on the next edge.
- No DONE pulse; ECHO unchanged from its reset value.

States: CLEAR -> IDLE -> SHIFT -> GAP -> IDLE.
- CLEAR: DAC_CLR=0 for CLR_CYCLES clocks after RESET deasserts, then DAC_CLR=1 and go to IDLE. DAC_CLR stays 1 thereafter.
- IDLE: IN_READY=1 (registered).
  - Handshake occurs on an edge where IN_VALID & IN_READY.
  - If !IN_BROADCAST and IN_CHANNEL >= NUM_CHANNELS: ERROR pulses next cycle, no frame, remain IDLE (IN_READY stays 1).
  - Otherwise latch frame, IN_READY=0, go to SHIFT.
- Frame layout (bit31 first):
  - [31:24]=8'h00
  - [23:20]=IN_CMD
  - [19:16]=IN_BROADCAST ? 4'hF : IN_CHANNEL
  - [15:0]={IN_DATA, (16-DATA_WIDTH) zeros} (MSB-aligned)
- SHIFT:
  - Cycle after accept: DAC_CS=0, SPI_MOSI=bit31, SCK=0.
  - After CLK_DIV clocks SCK rises; MISO is sampled into the echo shift register at that edge.
  - After CLK_DIV more clocks SCK falls and MOSI advances to the next bit.
  - MOSI changes only while SCK is low.
  - After the 32nd falling edge, SCK stays low for one further half-period.
  - DAC_CS is low for exactly 65*CLK_DIV clocks; exactly 32 SCK pulses.
- Frame end (DAC_CS returns high):
  - DONE=1 for one cycle.
  - ECHO updated the same cycle.
  - CHECK increments (wraps 255->0).
  - MOSI=0.
- GAP: DAC_CS=1, IN_READY=0 for CS_GAP clocks, then IDLE.
- Throughput: a back-to-back accept is possible on the first IDLE cycle.

Accept rules:
- IN_* fields are sampled only at accept.
- Changes to IN_* while busy have no effect.
- IN_VALID while IN_READY=0 is held off, not dropped.

Test Plan:
1. Power-up clear (CLK_DIV=2, CLR_CYCLES=4): RESET high 3 clocks then low -> DAC_CLR low exactly 4 clocks after release; IN_READY rises the cycle after DAC_CLR rises; DAC_CS=1, SCK=0 throughout.
2. Single write: IN_CMD=3, IN_CHANNEL=2, IN_DATA=12'hABC -> MOSI frame 32'h0032ABC0 sampled on SCK rising edges; 32 pulses; CS low 130 clocks; DONE one cycle; CHECK=1.
3. Broadcast + echo: IN_BROADCAST=1, IN_CHANNEL=7, IN_DATA=12'h800, MISO driven with 32'hDEADBEEF (changing on SCK falling edges) -> frame 32'h003F8000; ECHO=32'hDEADBEEF at DONE.
4. Bad channel: IN_CHANNEL=5 with NUM_CHANNELS=4 -> ERROR pulse, DAC_CS never falls, CHECK unchanged, IN_READY stays 1.
5. Back-to-back with IN_VALID held high: 3 commands -> CS high exactly CS_GAP=4 clocks between frames; CHECK=3; IN_* changes mid-frame are ignored.
6. Reset at bit 10 of a frame -> next edge CS=1, SCK=0, MOSI=0; no DONE; DAC_CLR re-clears; CHECK=0; a subsequent frame is correct.
